// File: rtl/secuenciador_control_if.sv
// Handshake/bus bundle between the control sequencer and its environment
// (program ROM, 4-bit bus-driver/ALU/accumulator datapath, I/O handshakes).
//   master : sequencer side (drives ROM address and datapath controls)
//   slave  : environment side (ROM data, datapath flags, I/O handshakes)
// Signals:
//   pc_addr[PC_W]  ROM address          instr[8]      ROM data (1-cycle latency)
//   bus_data[4]    input bus value      bus_en        input bus driver enable
//   alu_op[3]      ALU operation        acc_en        accumulator enable
//   acc_store      accumulator strobe   out_en        output bus driver enable
//   z_flag/c_flag  datapath flags       in_data[4]    external input word
//   in_valid/in_ready, out_valid/out_ready  input/output handshakes
//   halted         sticky HALT status   illegal       sticky undefined-opcode status
interface secuenciador_control_if #(
  parameter int unsigned PC_W = 4
) ();
  logic [PC_W-1:0] pc_addr;
  logic [7:0]      instr;
  logic [3:0]      bus_data;
  logic            bus_en;
  logic [2:0]      alu_op;
  logic            acc_en;
  logic            acc_store;
  logic            out_en;
  logic            z_flag;
  logic            c_flag;
  logic [3:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic            halted;
  logic            illegal;

  modport master (
    output pc_addr, bus_data, bus_en, alu_op, acc_en, acc_store, out_en,
           in_ready, out_valid, halted, illegal,
    input  instr, z_flag, c_flag, in_data, in_valid, out_ready
  );

  modport slave (
    input  pc_addr, bus_data, bus_en, alu_op, acc_en, acc_store, out_en,
           in_ready, out_valid, halted, illegal,
    output instr, z_flag, c_flag, in_data, in_valid, out_ready
  );
endinterface

// File: rtl/secuenciador_control.sv
// Control sequencer for the 4-bit bus-driver/ALU/accumulator datapath.
// Fetches 8-bit instructions ([7:4] opcode, [3:0] operand k) from a synchronous
// ROM and sequences FETCH -> DECODE -> EXEC (+ WAIT_IN / WAIT_OUT / HALT).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   step   (only with SECUENCIADOR_STEP_EN) FETCH advances only when step=1
//   bus    secuenciador_control_if.master: ROM, datapath controls, handshakes
// Optional feature macro: SECUENCIADOR_STEP_EN (single-step control input).
module secuenciador_control #(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef SECUENCIADOR_STEP_EN
  input  logic                         step,
`endif
  secuenciador_control_if.master       bus
);

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_WAIT_IN, ST_WAIT_OUT, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LIT = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_NAND = 4'h4, OP_OUT = 4'h5, OP_JMP = 4'h6, OP_JZ  = 4'h7,
    OP_JC   = 4'h8, OP_IN  = 4'h9, OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS_ACC = 3'b000, ALU_SUB = 3'b001, ALU_PASS_BUS = 3'b010,
    ALU_ADD      = 3'b011, ALU_NAND = 3'b100
  } alu_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic            z_reg, c_reg;
  logic            halted_r, illegal_r;
  logic            fetch_go;
  logic [3:0]      opc;
  logic [PC_W-1:0] k_ext;

  assign opc   = ir[7:4];
  assign k_ext = PC_W'(ir[3:0]);

`ifdef SECUENCIADOR_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH;
      pc        <= PC_W'(RESET_PC);
      ir        <= '0;
      z_reg     <= 1'b0;
      c_reg     <= 1'b0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      case (state)
        ST_FETCH:  if (fetch_go) state <= ST_DECODE;
        ST_DECODE: begin
          ir    <= bus.instr;
          pc    <= pc + PC_W'(1);
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          case (opc)
            OP_LIT, OP_ADD, OP_SUB, OP_NAND: begin
              z_reg <= bus.z_flag;
              c_reg <= bus.c_flag;
            end
            OP_JMP:  pc <= k_ext;
            OP_JZ:   if (z_reg) pc <= k_ext;
            OP_JC:   if (c_reg) pc <= k_ext;
            OP_IN:   state <= ST_WAIT_IN;
            OP_OUT:  state <= ST_WAIT_OUT;
            OP_HALT: begin
              state    <= ST_HALT;
              halted_r <= 1'b1;
            end
            OP_NOP:  ;
            default: illegal_r <= 1'b1;
          endcase
        end
        ST_WAIT_IN: if (bus.in_valid) begin
          z_reg <= bus.z_flag;
          c_reg <= bus.c_flag;
          state <= ST_FETCH;
        end
        ST_WAIT_OUT: if (bus.out_ready) state <= ST_FETCH;
        ST_HALT:     state <= ST_HALT;
        default:     state <= ST_FETCH;
      endcase
    end
  end

  // Controls decode from state/ir/pc; WAIT_IN bus/accumulator controls
  // follow in_valid combinationally so the word is captured in the same cycle.
  always_comb begin
    bus.pc_addr   = pc;
    bus.bus_data  = '0;
    bus.bus_en    = 1'b0;
    bus.alu_op    = ALU_PASS_ACC;
    bus.acc_en    = 1'b0;
    bus.acc_store = 1'b0;
    bus.out_en    = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.halted    = halted_r;
    bus.illegal   = illegal_r;
    case (state)
      ST_EXEC: begin
        if (opc == OP_LIT || opc == OP_ADD || opc == OP_SUB || opc == OP_NAND) begin
          bus.bus_en    = 1'b1;
          bus.bus_data  = ir[3:0];
          bus.acc_en    = 1'b1;
          bus.acc_store = 1'b1;
          case (opc)
            OP_LIT:  bus.alu_op = ALU_PASS_BUS;
            OP_ADD:  bus.alu_op = ALU_ADD;
            OP_SUB:  bus.alu_op = ALU_SUB;
            default: bus.alu_op = ALU_NAND;
          endcase
        end
      end
      ST_WAIT_IN: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.bus_en    = 1'b1;
          bus.bus_data  = bus.in_data;
          bus.alu_op    = ALU_PASS_BUS;
          bus.acc_en    = 1'b1;
          bus.acc_store = 1'b1;
        end
      end
      ST_WAIT_OUT: begin
        bus.out_en    = 1'b1;
        bus.alu_op    = ALU_PASS_ACC;
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
